mult_div_unit: RTL and testbench

//   Iterative 32-bit multiply/divide unit holding the architectural HI/LO pair.

---
 rtl/mult_div_unit.sv | 134 +++++++++++++
 tb/tb_mult_div_unit.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative WIDTH-bit MULT/MULTU/DIV/DIVU unit that owns the HI/LO pair. Results land WIDTH cycles after start.
// No backpressure: start, hi_write and lo_write are dropped while busy. start is accepted again in the done cycle.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             hi_write,
  input  logic             lo_write,
  input  logic [WIDTH-1:0] write_data,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] acc_hi_q, acc_lo_q, b_q, hi_q, lo_q;
  logic             is_div_q, neg_q_q, neg_r_q, dbz_q;

  logic             accept, last_step;
  logic             sign_a, sign_b;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   mul_sum, div_shift;
  logic [WIDTH+1:0] div_diff;
  logic [WIDTH-1:0] step_hi, step_lo, res_hi, res_lo;
  logic [2*WIDTH-1:0] product;

  assign accept    = start && (state_q != RUN);
  assign last_step = (count_q == CW'(WIDTH - 1));

  assign busy        = (state_q == RUN);
  assign done        = (state_q == FINISH);
  assign div_by_zero = done && dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_step) state_d = FINISH;
      FINISH:  state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    // op[0]==0 selects the signed variants
    sign_a = !op[0] && operand_a[WIDTH-1];
    sign_b = !op[0] && operand_b[WIDTH-1];
    abs_a  = sign_a ? -operand_a : operand_a;
    abs_b  = sign_b ? -operand_b : operand_b;

    mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, b_q} : '0);
    div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, b_q};

    if (is_div_q) begin
      // restoring step: keep the shifted remainder when the subtract borrows
      step_hi = div_diff[WIDTH+1] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
      step_lo = {acc_lo_q[WIDTH-2:0], !div_diff[WIDTH+1]};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
    end

    product = {step_hi, step_lo};
    if (neg_q_q) product = -product;

    if (is_div_q) begin
      // a zero divisor yields remainder |a|; re-applying a's sign restores a
      res_lo = dbz_q ? '1 : (neg_q_q ? -step_lo : step_lo);
      res_hi = neg_r_q ? -step_hi : step_hi;
    end else begin
      res_hi = product[2*WIDTH-1:WIDTH];
      res_lo = product[WIDTH-1:0];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q  <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      dbz_q    <= 1'b0;
    end else if (accept) begin
      count_q  <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= abs_a;
      b_q      <= abs_b;
      is_div_q <= op[1];
      neg_q_q  <= sign_a ^ sign_b;
      neg_r_q  <= sign_a;
      dbz_q    <= op[1] && (operand_b == '0);
    end else if (state_q == RUN) begin
      count_q  <= last_step ? '0 : count_q + 1'b1;
      acc_hi_q <= step_hi;
      acc_lo_q <= step_lo;
      if (last_step) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end
    end else begin
      if (hi_write) hi_q <= write_data;
      if (lo_write) lo_q <= write_data;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed and random checks of mult_div_unit against a queue of expected HI/LO results.
module tb_mult_div_unit;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] operand_a = '0, operand_b = '0, write_data = '0;
  logic        hi_write = 1'b0, lo_write = 1'b0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  exp_t sb_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b),
    .hi_write(hi_write), .lo_write(lo_write), .write_data(write_data),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint sa, sb, sq, sr;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.dbz = 1'b0;
    case (o)
      2'b00: begin p = 64'(sa * sb); e.hi = p[63:32]; e.lo = p[31:0]; end
      2'b01: begin p = {32'b0, a} * {32'b0, b}; e.hi = p[63:32]; e.lo = p[31:0]; end
      default: begin
        if (b == 32'b0) begin
          e.dbz = 1'b1; e.hi = a; e.lo = 32'hFFFF_FFFF;
        end else if (o == 2'b10) begin
          sq = sa / sb; sr = sa % sb;
          e.hi = sr[31:0]; e.lo = sq[31:0];
        end else begin
          e.hi = a % b; e.lo = a / b;
        end
      end
    endcase
    return e;
  endfunction

  // Called at #1 after an edge; returns #1 after the edge that takes start.
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input logic ed);
    exp_t e;
    e.hi = eh; e.lo = el; e.dbz = ed;
    sb_q.push_back(e);
    start = 1'b1; op = o; operand_a = a; operand_b = b;
    @(posedge clock); #1;
    start = 1'b0; hi_write = 1'b0; lo_write = 1'b0;
    operand_a = 32'h1357_9BDF; operand_b = 32'h0;
    check("busy_after_start", {63'b0, busy}, 64'd1);
    check("dbz_while_busy", {63'b0, div_by_zero}, 64'd0);
  endtask

  task automatic launch_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e = model(o, a, b);
    launch(o, a, b, e.hi, e.lo, e.dbz);
  endtask

  task automatic wait_done(input int exp_lat, input string tag);
    int   n;
    exp_t e;
    n = 0;
    while (!done && n < 40) begin
      @(posedge clock); #1;
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'(exp_lat));
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd0, 64'd1);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_hi"}, {32'b0, hi}, {32'b0, e.hi});
      check({tag, "_lo"}, {32'b0, lo}, {32'b0, e.lo});
      check({tag, "_dbz"}, {63'b0, div_by_zero}, {63'b0, e.dbz});
      check({tag, "_busy_in_done"}, {63'b0, busy}, 64'd0);
    end
  endtask

  task automatic idle_step(input string tag);
    @(posedge clock); #1;
    check({tag, "_done_cleared"}, {62'b0, done, div_by_zero}, 64'd0);
  endtask

  initial begin
    logic [31:0] ra, rb, hold_hi, hold_lo;
    logic [1:0]  rop;

    repeat (2) @(posedge clock);
    #1;
    check("reset_busy", {63'b0, busy}, 64'd0);
    check("reset_done_dbz", {62'b0, done, div_by_zero}, 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    reset_n = 1'b1;
    @(posedge clock); #1;

    launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    wait_done(32, "multu_max");
    idle_step("multu_max");

    launch(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    wait_done(32, "mult_neg");
    idle_step("mult_neg");

    launch(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    wait_done(32, "div_neg");
    idle_step("div_neg");

    launch(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    wait_done(32, "divu_100_7");
    idle_step("divu_100_7");

    launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
    wait_done(32, "div_overflow");
    idle_step("div_overflow");

    launch(2'b11, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1);
    wait_done(32, "divu_by_zero");
    idle_step("divu_by_zero");

    launch(2'b10, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1);
    wait_done(32, "div_neg_by_zero");
    idle_step("div_neg_by_zero");

    // MTHI and MTLO together, then idle cycles with op set but no start
    hi_write = 1'b1; lo_write = 1'b1; write_data = 32'h0000_A5A5;
    @(posedge clock); #1;
    hi_write = 1'b0; lo_write = 1'b0;
    check("mthi_mtlo", {hi, lo}, 64'h0000_A5A5_0000_A5A5);
    op = 2'b00; operand_a = 32'd9; operand_b = 32'd9;
    repeat (3) @(posedge clock);
    #1;
    check("hold_without_start", {hi, lo}, 64'h0000_A5A5_0000_A5A5);
    check("idle_not_busy", {63'b0, busy}, 64'd0);

    // start and MTHI in the same cycle: start takes it, hi keeps its value
    hi_write = 1'b1; write_data = 32'h0000_5555;
    launch(2'b01, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0);
    check("start_beats_mthi", {32'b0, hi}, 64'h0000_A5A5);
    wait_done(32, "multu_3_4");
    idle_step("multu_3_4");

    // inputs wiggled while busy, then a second op launched in the done cycle
    launch(2'b10, 32'd1000, 32'hFFFF_FFFD, 32'd1, 32'hFFFF_FEB3, 1'b0);
    repeat (5) @(posedge clock);
    #1;
    start = 1'b1; op = 2'b11; operand_a = 32'd77; operand_b = 32'd3;
    hi_write = 1'b1; lo_write = 1'b1; write_data = 32'hDEAD_BEEF;
    hold_hi = hi; hold_lo = lo;
    @(posedge clock); #1;
    start = 1'b0; hi_write = 1'b0; lo_write = 1'b0;
    check("ignored_while_busy", {hi, lo}, {hold_hi, hold_lo});
    check("still_busy", {63'b0, busy}, 64'd1);
    wait_done(26, "div_busy_inputs");
    launch(2'b11, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, 1'b0);
    wait_done(32, "back_to_back");
    idle_step("back_to_back");

    for (int i = 0; i < 6; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom >> $urandom_range(0, 28);
      launch_model(rop, ra, rb);
      wait_done(32, $sformatf("random_%0d", i));
      idle_step($sformatf("random_%0d", i));
    end

    // reset in the middle of a divide
    launch(2'b10, 32'd123456, 32'd789, 32'd372, 32'd156, 1'b0);
    repeat (9) @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    check("midop_reset_busy", {62'b0, busy, done}, 64'd0);
    check("midop_reset_hilo", {hi, lo}, 64'd0);
    sb_q.delete();
    @(posedge clock); #1;
    reset_n = 1'b1;
    lo_write = 1'b1; write_data = 32'h0000_1234;
    @(posedge clock); #1;
    lo_write = 1'b0;
    check("mtlo_after_reset", {hi, lo}, 64'h0000_0000_0000_1234);
    repeat (3) @(posedge clock);
    #1;
    check("no_stale_done", {62'b0, done, busy}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
